instr_fetch_unit: RTL

Front-end fetch stage of the 16-bit MicroProcessor. It owns the program counter and issues word reads to a synchronous instruction memory. Returned instructions are buffered in a small prefetch queue and handed downstream to decode/register-read with their PC over a valid/ready handshake. Redirects from branch/jump resolution flush in-flight fetches and restart at the target address.

---
 rtl/mp_pkg.sv | 14 +
 rtl/fetch_queue.sv | 49 ++++
 rtl/instr_fetch_unit.sv | 77 +++++++
 3 files changed

// File: rtl/mp_pkg.sv
// Shared MicroProcessor types: address/data widths, reset PC and the fetch-entry record.
// Reused by the fetch, decode and register-read stages.
package mp_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries; push and pop take effect at the next edge, head is read from storage.
// Caller must never push into a full queue without a same-cycle pop; flush empties it in one cycle.
module fetch_queue #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic [31:0],
    localparam int PW      = $clog2(DEPTH),
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          clr,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output entry_t        head
);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;

    always_ff @(posedge clock) begin
        if (!clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one imem read per cycle, buffers responses for decode; 2-cycle first latency.
// Issue stalls once buffered + in-flight reaches DEPTH; redirects flush and restart with a 2-bubble penalty.
module instr_fetch_unit #(
    parameter int                          DEPTH    = 4,
    parameter logic [mp_pkg::ADDR_W-1:0]   RESET_PC = mp_pkg::RESET_PC
) (
    input  logic                        clock,
    input  logic                        clr,
    output logic                        imem_req,
    output logic [mp_pkg::ADDR_W-1:0]   imem_addr,
    input  logic [mp_pkg::DATA_W-1:0]   imem_rdata,
    input  logic                        redirect_valid,
    input  logic [mp_pkg::ADDR_W-1:0]   redirect_pc,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [mp_pkg::DATA_W-1:0]   inst,
    output logic [mp_pkg::ADDR_W-1:0]   PC
);

    import mp_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_pc;
    logic              inflight;
    logic [CW-1:0]     count;
    logic [CW:0]       occupancy;
    logic              push;
    logic              pop;
    fetch_entry_t      push_data;
    fetch_entry_t      head;

    // A pop in the same cycle does not free a slot for issue; keeps the check off the ready path.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign imem_req  = clr & ~redirect_valid & (occupancy < (CW + 1)'(DEPTH));
    assign imem_addr = fetch_pc;

    assign push      = inflight & ~redirect_valid;
    assign pop       = out_valid & out_ready;
    assign push_data = '{pc: req_pc, inst: imem_rdata};

    always_ff @(posedge clock) begin
        if (!clr) begin
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
            req_pc   <= '0;
        end else begin
            inflight <= imem_req;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
            end else if (imem_req) begin
                fetch_pc <= fetch_pc + ADDR_W'(1);
                req_pc   <= fetch_pc;
            end
        end
    end

    fetch_queue #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_queue (
        .clock     (clock),
        .clr       (clr),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (count),
        .head      (head)
    );

    assign out_valid = (count != '0);
    assign inst      = head.inst;
    assign PC        = head.pc;

endmodule
